// File: rtl/unit_b_seq_pkg.sv
// Shared types and sizing helpers for the unitB convolution sequencer.
// Imported by the sequencer top and its weight-address generator.
package unit_b_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StWaitIf,
    StConv,
    StCwait,
    StAccu,
    StRelu,
    StDone
  } seq_state_e;

  // Weights per depth slice for the default 5x5 kernel.
  localparam int unsigned KK = 25;

  function automatic int unsigned taps(input int unsigned ks);
    return ks * ks;
  endfunction

  // Counter width that holds 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wm_addr_gen.sv
// Weight RAM read burst: base address from filter/depth, KK sequential reads,
// and the FIFO shift enable trailing the registered RAM read by one cycle.
module wm_addr_gen
  import unit_b_seq_pkg::*;
#(
  parameter int unsigned IFM_DEPTH        = 6,
  parameter int unsigned KERNAL_SIZE      = 5,
  parameter int unsigned FILTERS_PER_UNIT = 6,
  parameter int unsigned ADDRESS_SIZE_WM  =
      $clog2(KERNAL_SIZE * KERNAL_SIZE * IFM_DEPTH * FILTERS_PER_UNIT),
  parameter int unsigned FSEL_W           = cnt_w(FILTERS_PER_UNIT),
  parameter int unsigned DEPTH_W          = cnt_w(IFM_DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       burst_start,
  input  logic [FSEL_W-1:0]          fsel,
  input  logic [DEPTH_W-1:0]         depth,
  output logic                       wm_enable_read,
  output logic [ADDRESS_SIZE_WM-1:0] wm_address,
  output logic                       wm_fifo_enable,
  output logic                       burst_last
);

  localparam int unsigned NUM_TAPS = taps(KERNAL_SIZE);
  localparam int unsigned K_W      = cnt_w(NUM_TAPS);
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_TAPS - 1);

  logic [K_W-1:0]             k_q;
  logic [ADDRESS_SIZE_WM-1:0] base;

  always_comb begin
    base = ADDRESS_SIZE_WM'((32'(fsel) * IFM_DEPTH + 32'(depth)) * NUM_TAPS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wm_enable_read <= 1'b0;
      wm_address     <= '0;
      wm_fifo_enable <= 1'b0;
      k_q            <= '0;
    end else begin
      wm_fifo_enable <= wm_enable_read;
      if (burst_start) begin
        wm_enable_read <= 1'b1;
        wm_address     <= base;
        k_q            <= '0;
      end else if (wm_enable_read) begin
        if (k_q == K_LAST) begin
          wm_enable_read <= 1'b0;
        end else begin
          k_q        <= k_q + K_W'(1);
          wm_address <= wm_address + ADDRESS_SIZE_WM'(1);
        end
      end
    end
  end

  // Only true on the trailing FIFO shift after the last read.
  assign burst_last = wm_fifo_enable & ~wm_enable_read;

endmodule

// File: rtl/unit_b_sequencer.sv
// Control FSM for one unitB convolution unit: per output pixel walks the IFM
// depth slices (load weights, convolve, accumulate), then applies ReLU.
module unit_b_sequencer
  import unit_b_seq_pkg::*;
#(
  parameter int unsigned IFM_DEPTH        = 6,
  parameter int unsigned KERNAL_SIZE      = 5,
  parameter int unsigned FILTERS_PER_UNIT = 6,
  parameter int unsigned OFM_PIXELS       = 100,
  parameter int unsigned CONV_LATENCY     = 3,
  parameter int unsigned ADDRESS_SIZE_WM  =
      $clog2(KERNAL_SIZE * KERNAL_SIZE * IFM_DEPTH * FILTERS_PER_UNIT),
  parameter int unsigned FSEL_W           = cnt_w(FILTERS_PER_UNIT)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [FSEL_W-1:0]          filter_sel,
  input  logic                       ifm_ready,
  output logic                       ifm_next,
  output logic                       wm_enable_read,
  output logic [ADDRESS_SIZE_WM-1:0] wm_address,
  output logic                       wm_fifo_enable,
  output logic                       conv_enable,
  output logic                       accu_enable,
  output logic                       accu_first,
  output logic                       relu_enable,
  output logic                       pixel_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned DEPTH_W = cnt_w(IFM_DEPTH);
  localparam int unsigned PIX_W   = cnt_w(OFM_PIXELS);
  localparam int unsigned LAT_W   = cnt_w(CONV_LATENCY);

  localparam logic [DEPTH_W-1:0] DEPTH_LAST = DEPTH_W'(IFM_DEPTH - 1);
  localparam logic [PIX_W-1:0]   PIX_LAST   = PIX_W'(OFM_PIXELS - 1);
  localparam logic [LAT_W-1:0]   LAT_INIT   = LAT_W'(CONV_LATENCY - 1);

  seq_state_e         state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [PIX_W-1:0]   pixel_q, pixel_d;
  logic [FSEL_W-1:0]  fsel_q, fsel_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               burst_start;
  logic               burst_last;

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    pixel_d     = pixel_q;
    fsel_d      = fsel_q;
    lat_d       = lat_q;
    burst_start = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && !busy) begin
          state_d     = StLoadW;
          fsel_d      = filter_sel;
          depth_d     = '0;
          pixel_d     = '0;
          burst_start = 1'b1;
        end
      end
      StLoadW: begin
        if (burst_last) begin
          state_d = StWaitIf;
        end
      end
      StWaitIf: begin
        if (ifm_ready) begin
          state_d = StConv;
        end
      end
      StConv: begin
        state_d = StCwait;
        lat_d   = LAT_INIT;
      end
      StCwait: begin
        if (lat_q == '0) begin
          state_d = StAccu;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      StAccu: begin
        if (depth_q != DEPTH_LAST) begin
          state_d     = StLoadW;
          depth_d     = depth_q + DEPTH_W'(1);
          burst_start = 1'b1;
        end else begin
          state_d = StRelu;
        end
      end
      StRelu: begin
        if (pixel_q != PIX_LAST) begin
          state_d     = StLoadW;
          pixel_d     = pixel_q + PIX_W'(1);
          depth_d     = '0;
          burst_start = 1'b1;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Strobes are decoded from the next state so each one is a register output
  // that lines up with the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      depth_q     <= '0;
      pixel_q     <= '0;
      fsel_q      <= '0;
      lat_q       <= '0;
      ifm_next    <= 1'b0;
      conv_enable <= 1'b0;
      accu_enable <= 1'b0;
      accu_first  <= 1'b0;
      relu_enable <= 1'b0;
      pixel_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      pixel_q     <= pixel_d;
      fsel_q      <= fsel_d;
      lat_q       <= lat_d;
      ifm_next    <= ((state_d == StAccu) && (depth_d != DEPTH_LAST)) ||
                     ((state_d == StRelu) && (pixel_d != PIX_LAST));
      conv_enable <= (state_d == StConv);
      accu_enable <= (state_d == StAccu);
      accu_first  <= (state_d == StAccu) && (depth_d == '0);
      relu_enable <= (state_d == StRelu);
      pixel_valid <= (state_d == StRelu);
      busy        <= (state_d != StIdle);
      done        <= (state_d == StDone);
    end
  end

  wm_addr_gen #(
    .IFM_DEPTH        (IFM_DEPTH),
    .KERNAL_SIZE      (KERNAL_SIZE),
    .FILTERS_PER_UNIT (FILTERS_PER_UNIT),
    .ADDRESS_SIZE_WM  (ADDRESS_SIZE_WM),
    .FSEL_W           (FSEL_W),
    .DEPTH_W          (DEPTH_W)
  ) u_wm_addr_gen (
    .clk            (clk),
    .reset          (reset),
    .burst_start    (burst_start),
    .fsel           (fsel_d),
    .depth          (depth_d),
    .wm_enable_read (wm_enable_read),
    .wm_address     (wm_address),
    .wm_fifo_enable (wm_fifo_enable),
    .burst_last     (burst_last)
  );

endmodule

// File: tb/tb_unit_b_sequencer.sv
// Randomized bench for unit_b_sequencer: expected per-cycle output trace is
// built from the run schedule (slice/pixel phases), then compared cycle by cycle.
module tb_unit_b_sequencer;
  import unit_b_seq_pkg::*;

  localparam int IFM_DEPTH  = 2;
  localparam int OFM_PIXELS = 3;
  localparam int CONV_LAT   = 2;
  localparam int FILTERS    = 6;
  localparam int KS         = 5;
  localparam int AW         = $clog2(KS * KS * IFM_DEPTH * FILTERS);
  localparam int FW         = $clog2(FILTERS);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [FW-1:0] filter_sel;
  logic          ifm_ready;
  logic          ifm_next, wm_enable_read, wm_fifo_enable, conv_enable;
  logic          accu_enable, accu_first, relu_enable, pixel_valid, busy, done;
  logic [AW-1:0] wm_address;

  always #5 clk = ~clk;

  unit_b_sequencer #(
    .IFM_DEPTH        (IFM_DEPTH),
    .KERNAL_SIZE      (KS),
    .FILTERS_PER_UNIT (FILTERS),
    .OFM_PIXELS       (OFM_PIXELS),
    .CONV_LATENCY     (CONV_LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .filter_sel     (filter_sel),
    .ifm_ready      (ifm_ready),
    .ifm_next       (ifm_next),
    .wm_enable_read (wm_enable_read),
    .wm_address     (wm_address),
    .wm_fifo_enable (wm_fifo_enable),
    .conv_enable    (conv_enable),
    .accu_enable    (accu_enable),
    .accu_first     (accu_first),
    .relu_enable    (relu_enable),
    .pixel_valid    (pixel_valid),
    .busy           (busy),
    .done           (done)
  );

  always @(posedge clk) begin
    if (!reset && start && !busy) begin
      assert (filter_sel < FILTERS)
        else $error("FAIL filter_sel_legal: got %0d, required < %0d", filter_sel, FILTERS);
    end
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic rd, fifo, conv, accu, first, relu, pv, nxt, bsy, dn;
  } exp_t;

  exp_t exp_q[$];
  bit   rdy_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [9:0] obs_status();
    return {wm_enable_read, wm_fifo_enable, conv_enable, accu_enable, accu_first,
            relu_enable, pixel_valid, ifm_next, busy, done};
  endfunction

  function automatic logic [9:0] exp_status(input exp_t e);
    return {e.rd, e.fifo, e.conv, e.accu, e.first, e.relu, e.pv, e.nxt, e.bsy, e.dn};
  endfunction

  task automatic push(input exp_t e, input bit r);
    exp_q.push_back(e);
    rdy_q.push_back(r);
  endtask

  // mode 0: ifm_ready tied high; 1: random ready delay; 2: also one 10-cycle stall
  task automatic build_run(input int fsel, input int mode);
    exp_t e;
    int   base, w;
    exp_q.delete();
    rdy_q.delete();
    for (int p = 0; p < OFM_PIXELS; p++) begin
      for (int d = 0; d < IFM_DEPTH; d++) begin
        base = (fsel * IFM_DEPTH + d) * KK;
        for (int c = 0; c <= KK; c++) begin
          e = '0;
          e.bsy  = 1'b1;
          e.rd   = (c < KK);
          e.addr = (c < KK) ? AW'(base + c) : '0;
          e.fifo = (c >= 1);
          push(e, (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
        end
        if (mode == 0) w = 0;
        else if (mode == 2 && p == 1 && d == 0) w = 10;
        else w = $urandom_range(0, 3);
        for (int j = 0; j <= w; j++) begin
          e = '0;
          e.bsy = 1'b1;
          push(e, (mode == 0) ? 1'b1 : (j == w));
        end
        e = '0; e.bsy = 1'b1; e.conv = 1'b1;
        push(e, (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
        for (int l = 0; l < CONV_LAT; l++) begin
          e = '0; e.bsy = 1'b1;
          push(e, (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
        end
        e = '0; e.bsy = 1'b1; e.accu = 1'b1;
        e.first = (d == 0);
        e.nxt   = (d < IFM_DEPTH - 1);
        push(e, 1'b1);
        if (d == IFM_DEPTH - 1) begin
          e = '0; e.bsy = 1'b1; e.relu = 1'b1; e.pv = 1'b1;
          e.nxt = (p < OFM_PIXELS - 1);
          push(e, 1'b1);
        end
      end
    end
    e = '0; e.bsy = 1'b1; e.dn = 1'b1;
    push(e, 1'b0);
    for (int i = 0; i < 3; i++) begin
      e = '0;
      push(e, 1'b0);
    end
  endtask

  // abort_in_cwait: assert reset in the first CWAIT cycle instead of finishing
  task automatic run_trace(input int fsel, input int mode, input bit stray,
                           input bit abort_in_cwait);
    int pv_cnt = 0, nxt_cnt = 0, dn_cnt = 0, last_pv = -1, max_addr = 0;
    build_run(fsel, mode);
    @(negedge clk);
    start      = 1'b1;
    filter_sel = FW'(fsel);
    ifm_ready  = 1'($urandom_range(0, 1));
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check_eq($sformatf("ctl[f%0d m%0d c%0d]", fsel, mode, i), 32'(obs_status()),
               32'(exp_status(exp_q[i])));
      if (exp_q[i].rd) begin
        check_eq($sformatf("addr[f%0d c%0d]", fsel, i), 32'(wm_address), 32'(exp_q[i].addr));
        if (int'(wm_address) > max_addr) max_addr = int'(wm_address);
      end
      if (pixel_valid) begin
        if (mode == 0 && last_pv >= 0) check_eq("pv_spacing", i - last_pv, 63);
        last_pv = i;
        pv_cnt++;
      end
      if (ifm_next) nxt_cnt++;
      if (done) dn_cnt++;
      if (abort_in_cwait && i > 0 && exp_q[i-1].conv) begin
        reset = 1'b1;
        start = 1'b0;
        #1;
        check_eq("rst_async", {22'(0), obs_status()} | 32'(wm_address), 0);
        @(negedge clk);
        check_eq("rst_held", {22'(0), obs_status()} | 32'(wm_address), 0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          check_eq("rst_idle_no_done", 32'(obs_status()), 0);
        end
        return;
      end
      ifm_ready  = rdy_q[i];
      start      = (stray && exp_q[i].bsy) ? 1'($urandom_range(0, 1)) : 1'b0;
      filter_sel = FW'($urandom_range(0, FILTERS - 1));
    end
    check_eq("pixel_valid_count", pv_cnt, OFM_PIXELS);
    check_eq("ifm_next_count", nxt_cnt, OFM_PIXELS * IFM_DEPTH - 1);
    check_eq("done_count", dn_cnt, 1);
    if (fsel == 5) check_eq("last_addr_f5", max_addr, 299);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    filter_sel = '0;
    ifm_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_held", {22'(0), obs_status()} | 32'(wm_address), 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("reset_released", {22'(0), obs_status()} | 32'(wm_address), 0);

    run_trace(1, 0, 1'b0, 1'b0);
    run_trace(3, 1, 1'b1, 1'b0);
    run_trace(0, 2, 1'b1, 1'b0);
    run_trace(2, 0, 1'b0, 1'b1);
    run_trace(4, 0, 1'b1, 1'b0);
    run_trace(5, 1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
